move_button_arbiter: RTL and testbench
======================================

// Module: move_button_arbiter
// PURPOSE
// - Conditions four raw player buttons into the single-cycle command pulses
//   that drive the movement/orientation update stage.
// - Per-button flow: 2-FF synchroniser, debouncer, rising-edge detector, pending latch.
// - A priority arbiter emits at most one command per pulse slot.
// - A hold-off gap after every pulse guarantees the downstream stage a free
//   cycle to commit its update.
// PARAMETERS
// - DEBOUNCE_CYCLES  1_000_000  cycles a synced level must stay changed before it is accepted (>=1)
// - HOLDOFF_CYCLES   4          idle cycles forced after each pulse (>=2)
// - REPEAT_DELAY     50_000_000 cycles after first pulse before auto-repeat starts (AUTO_REPEAT_EN only)
// - REPEAT_PERIOD    25_000_000 cycles between auto-repeat requests (AUTO_REPEAT_EN only)
// PORTS
// - clk_in          in   1  system clock
// - rst_n_in        in   1  reset: asynchronous assert, active-low
// - btn_fwd_in      in   1  raw forward button, asynchronous
// - btn_bwd_in      in   1  raw backward button, asynchronous
// - btn_left_in     in   1  raw rotate-left button, asynchronous
// - btn_right_in    in   1  raw rotate-right button, asynchronous
// - fwd_pulse       out  1  one-cycle forward command
// - bwd_pulse       out  1  one-cycle backward command
// - leftRot_pulse   out  1  one-cycle rotate-left command
// - rightRot_pulse  out  1  one-cycle rotate-right command
// - is_pulse        out  1  OR of the four command pulses, same cycle
// - btn_level       out  4  debounced levels {right,left,bwd,fwd}
// BEHAVIOUR
// - Reset: rst_n_in=0 clears all state asynchronously.
//   - Synchronisers, stable levels, counters and pending bits go to 0; FSM goes to IDLE.
//   - Every output reads 0 while in reset.
//   - Pending requests are dropped, not resumed.
// - Synchroniser: 2 flops per button; no logic between the flops.
// - Debounce, per button:
//   - cnt resets to 0 whenever sync==stable.
//   - Otherwise cnt increments; when cnt==DEBOUNCE_CYCLES-1, stable<=sync and cnt<=0.
//   - Any mismatch gap shorter than DEBOUNCE_CYCLES is ignored.
//   - cnt width is $clog2(DEBOUNCE_CYCLES+1) and it never wraps.
// - Edge and pending:
//   - Rising edge of stable in cycle T sets pending[i] in T+1; falling edges are ignored.
//   - pending is sticky until served. A set and a clear of the same bit in one cycle: set wins.
// - Arbiter FSM:
//   - IDLE: if pending!=0, select the highest priority bit (fwd > bwd > left > right).
//     The registered pulse and is_pulse are high the next cycle, for exactly one cycle.
//     The served bit is cleared, hold_cnt<=HOLDOFF_CYCLES, next state is HOLD.
//   - HOLD: all pulses 0; hold_cnt decrements; at 0 go to IDLE.
//     New edges still set pending during HOLD.
// - Timing:
//   - Latency from stable rise in T to pulse is T+2 when the arbiter is idle.
//   - Minimum spacing between is_pulse assertions is HOLDOFF_CYCLES+1 cycles.
//   - Simultaneous presses are served in priority order, one per slot; none is lost.
//   - Opposing commands (fwd+bwd, left+right) are both served, in priority order.
// - Outputs: exactly zero or one of the four pulses is high in any cycle (one-hot0).
//   is_pulse is never high without one of them.
// CONFIGURATION
// - Macro AUTO_REPEAT_EN.
// - Defined: per-button repeat counter, cleared while stable==0.
//   - First repeat request is REPEAT_DELAY cycles after the edge-generated request.
//   - Later requests follow every REPEAT_PERIOD cycles while stable==1.
//   - A request finding pending already set merges into it; no queue depth.
// - Undefined: one pulse per press regardless of hold time.
//   No repeat counters are synthesised, and REPEAT_* are unused.
// TESTING
// - Bench parameters: DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=10.
// - Reset: hold rst_n_in=0 with all buttons=1 -> every output 0.
//   Release -> first fwd_pulse at cycle 2+4+2 after release.
// - Clean press: btn_fwd 0->1, held 100 cycles -> exactly one fwd_pulse+is_pulse, width 1;
//   btn_level[0]=1; no further pulses (macro off).
// - Bounce: btn_left toggles every 2 cycles for 20 cycles, then held 1 -> exactly one leftRot_pulse;
//   no pulse during the bounce.
// - Simultaneous: btn_fwd and btn_right rise in the same cycle -> fwd_pulse at P,
//   rightRot_pulse at P+5, no other pulses.
// - Reset mid-HOLD with bwd pending: rst_n_in low 3 cycles -> outputs 0 immediately;
//   no bwd_pulse after release while buttons are 0.
// - AUTO_REPEAT_EN: hold btn_fwd 70 cycles past first pulse P -> fwd_pulse at P, P+20, P+30,
//   P+40, P+50, P+60, P+70; release -> no more.

Source files
------------

// File: rtl/move_button_arbiter.sv
// Button conditioning for four movement buttons: synchronise, debounce, edge-detect, arbitrate.
// Optional auto-repeat of held buttons is compiled in when AUTO_REPEAT_EN is defined.
module move_button_arbiter #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned HOLDOFF_CYCLES  = 4,
   parameter int unsigned REPEAT_DELAY    = 50_000_000,
   parameter int unsigned REPEAT_PERIOD   = 25_000_000
) (
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic       btn_fwd_in,
   input  logic       btn_bwd_in,
   input  logic       btn_left_in,
   input  logic       btn_right_in,
   output logic       fwd_pulse,
   output logic       bwd_pulse,
   output logic       leftRot_pulse,
   output logic       rightRot_pulse,
   output logic       is_pulse,
   output logic [3:0] btn_level
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
   localparam int unsigned HW = $clog2(HOLDOFF_CYCLES + 1);
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {
      IDLE,
      HOLD
   } state_t;

   logic [3:0]    btn_raw;
   logic [3:0]    sync1;
   logic [3:0]    sync2;
   logic [3:0]    stable;
   logic [3:0]    stable_d;
   logic [CW-1:0] db_cnt [4];
   logic [3:0]    rep_req;
   logic [3:0]    set_req;
   logic [3:0]    pending;
   logic [3:0]    pending_nxt;
   logic [3:0]    grant;
   logic [3:0]    pulse_q;
   logic [3:0]    pulse_nxt;
   logic [HW-1:0] hold_cnt;
   logic [HW-1:0] hold_nxt;
   state_t        state;
   state_t        state_nxt;

   assign btn_raw = {btn_right_in, btn_left_in, btn_bwd_in, btn_fwd_in};

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         sync1    <= '0;
         sync2    <= '0;
         stable   <= '0;
         stable_d <= '0;
         for (int unsigned i = 0; i < 4; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         sync1    <= btn_raw;
         sync2    <= sync1;
         stable_d <= stable;
         for (int unsigned i = 0; i < 4; i++) begin
            if (sync2[i] == stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               stable[i] <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

`ifdef AUTO_REPEAT_EN
   localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RW = $clog2(REP_MAX + 1);

   logic [RW-1:0] rep_cnt [4];
   logic [3:0]    rep_phase;

   // rep_cnt counts cycles since the latest request; phase selects delay vs period.
   always_comb begin
      rep_req = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         rep_req[i] = stable[i] && (rep_phase[i] ? (rep_cnt[i] == RW'(REPEAT_PERIOD))
                                                 : (rep_cnt[i] == RW'(REPEAT_DELAY)));
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rep_phase <= '0;
         for (int unsigned i = 0; i < 4; i++) begin
            rep_cnt[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (!stable[i]) begin
               rep_cnt[i]   <= '0;
               rep_phase[i] <= 1'b0;
            end else if (rep_req[i]) begin
               rep_cnt[i]   <= RW'(1);
               rep_phase[i] <= 1'b1;
            end else begin
               rep_cnt[i] <= rep_cnt[i] + 1'b1;
            end
         end
      end
   end
`else
   assign rep_req = '0;

   // Repeat timing is irrelevant without auto-repeat; this only references the parameters.
   if (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_repeat_unused
   end
`endif

   assign set_req = (stable & ~stable_d) | rep_req;

   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      pulse_nxt = '0;
      grant     = '0;
      case (state)
         IDLE: begin
            if (pending != '0) begin
               grant     = pending & (~pending + 4'd1);
               pulse_nxt = grant;
               hold_nxt  = HW'(HOLDOFF_CYCLES);
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            hold_nxt = hold_cnt - 1'b1;
            if (hold_cnt == HW'(1)) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // A new request on the bit being served in this cycle survives the clear.
      pending_nxt = (pending & ~grant) | set_req;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state    <= IDLE;
         hold_cnt <= '0;
         pending  <= '0;
         pulse_q  <= '0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;
         pending  <= pending_nxt;
         pulse_q  <= pulse_nxt;
      end
   end

   assign fwd_pulse      = pulse_q[0];
   assign bwd_pulse      = pulse_q[1];
   assign leftRot_pulse  = pulse_q[2];
   assign rightRot_pulse = pulse_q[3];
   assign is_pulse       = |pulse_q;
   assign btn_level      = stable;

endmodule

// File: tb/tb_move_button_arbiter.sv
// Scoreboard bench for move_button_arbiter; expected pulses (cycle, vector) are queued
// as stimulus is driven and matched by a negedge monitor.
module tb_move_button_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       btn_fwd = 1'b0;
   logic       btn_bwd = 1'b0;
   logic       btn_left = 1'b0;
   logic       btn_right = 1'b0;
   logic       fwd_pulse;
   logic       bwd_pulse;
   logic       leftRot_pulse;
   logic       rightRot_pulse;
   logic       is_pulse;
   logic [3:0] btn_level;

   typedef struct {
      int unsigned at;
      logic [3:0]  vec;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned cyc = 0;
   int          errors = 0;
   int          checks = 0;
   logic [3:0]  obs;
   exp_t        mon_e;

   move_button_arbiter #(
      .DEBOUNCE_CYCLES(4),
      .HOLDOFF_CYCLES (4),
      .REPEAT_DELAY   (20),
      .REPEAT_PERIOD  (10)
   ) dut (
      .clk_in        (clk),
      .rst_n_in      (rst_n),
      .btn_fwd_in    (btn_fwd),
      .btn_bwd_in    (btn_bwd),
      .btn_left_in   (btn_left),
      .btn_right_in  (btn_right),
      .fwd_pulse     (fwd_pulse),
      .bwd_pulse     (bwd_pulse),
      .leftRot_pulse (leftRot_pulse),
      .rightRot_pulse(rightRot_pulse),
      .is_pulse      (is_pulse),
      .btn_level     (btn_level)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: invariants every cycle, and every observed pulse must match the queue head.
   always @(negedge clk) begin
      obs = {rightRot_pulse, leftRot_pulse, bwd_pulse, fwd_pulse};
      checks++;
      if (is_pulse !== |obs) begin
         errors++;
         $display("FAIL is_pulse_or: cyc=%0d is_pulse=%b pulses=%b", cyc, is_pulse, obs);
      end
      checks++;
      if ((obs & (obs - 4'd1)) !== 4'd0) begin
         errors++;
         $display("FAIL one_hot0: cyc=%0d pulses=%b", cyc, obs);
      end
      if (obs !== 4'd0) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: cyc=%0d got=%b want=none", cyc, obs);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.at !== cyc || mon_e.vec !== obs) begin
               errors++;
               $display("FAIL pulse_slot: got cyc=%0d vec=%b, want cyc=%0d vec=%b",
                        cyc, obs, mon_e.at, mon_e.vec);
            end
         end
      end
   end

   task automatic tick(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_pulse(input int unsigned at, input logic [3:0] vec);
      exp_t e;
      e.at  = at;
      e.vec = vec;
      exp_q.push_back(e);
   endtask

   task automatic test_reset;
      int unsigned c;
      btn_fwd = 1'b1; btn_bwd = 1'b1; btn_left = 1'b1; btn_right = 1'b1;
      #2 rst_n = 1'b0;
      tick(3);
      checks++;
      if ({is_pulse, rightRot_pulse, leftRot_pulse, bwd_pulse, fwd_pulse, btn_level} !== 9'd0) begin
         errors++;
         $display("FAIL reset_outputs: got=%b want=0", {is_pulse, rightRot_pulse, leftRot_pulse,
                  bwd_pulse, fwd_pulse, btn_level});
      end
      rst_n = 1'b1;
      c = cyc;
      expect_pulse(c + 8,  4'b0001);
      expect_pulse(c + 13, 4'b0010);
      expect_pulse(c + 18, 4'b0100);
      expect_pulse(c + 23, 4'b1000);
      tick(15);
      checks++;
      if (btn_level !== 4'b1111) begin
         errors++;
         $display("FAIL reset_level_all: got=%b want=1111", btn_level);
      end
      btn_fwd = 1'b0; btn_bwd = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
      tick(20);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL reset_missing: got=%0d pending expectations want=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_clean_press;
      int unsigned c;
      c = cyc;
      btn_fwd = 1'b1;
      expect_pulse(c + 8, 4'b0001);
`ifdef AUTO_REPEAT_EN
      for (int unsigned k = 20; k <= 90; k += 10) expect_pulse(c + 8 + k, 4'b0001);
`endif
      tick(10);
      checks++;
      if (btn_level !== 4'b0001) begin
         errors++;
         $display("FAIL clean_level: got=%b want=0001", btn_level);
      end
      tick(90);
      btn_fwd = 1'b0;
      tick(30);
      checks++;
      if (btn_level !== 4'b0000) begin
         errors++;
         $display("FAIL clean_release_level: got=%b want=0000", btn_level);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL clean_missing: got=%0d pending expectations want=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_bounce;
      int unsigned c;
      c = cyc;
      for (int unsigned i = 0; i < 20; i++) begin
         btn_left = ((i / 2) % 2 == 0);
         tick(1);
      end
      checks++;
      if (btn_level !== 4'b0000) begin
         errors++;
         $display("FAIL bounce_level: got=%b want=0000", btn_level);
      end
      btn_left = 1'b1;
      expect_pulse(c + 28, 4'b0100);
      tick(15);
      checks++;
      if (btn_level !== 4'b0100) begin
         errors++;
         $display("FAIL bounce_settled_level: got=%b want=0100", btn_level);
      end
      btn_left = 1'b0;
      tick(25);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL bounce_missing: got=%0d pending expectations want=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_simultaneous;
      int unsigned c;
      c = cyc;
      btn_fwd = 1'b1;
      btn_right = 1'b1;
      expect_pulse(c + 8,  4'b0001);
      expect_pulse(c + 13, 4'b1000);
      tick(15);
      btn_fwd = 1'b0;
      btn_right = 1'b0;
      tick(25);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL simul_missing: got=%0d pending expectations want=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset_mid_hold;
      btn_fwd = 1'b1;
      btn_bwd = 1'b1;
      tick(8);
      // Pulse cycle is checked here directly, since reset lands before the monitor samples it.
      checks++;
      if (fwd_pulse !== 1'b1 || btn_level !== 4'b0011) begin
         errors++;
         $display("FAIL midhold_pre: got fwd=%b level=%b want fwd=1 level=0011", fwd_pulse, btn_level);
      end
      rst_n = 1'b0;
      btn_fwd = 1'b0;
      btn_bwd = 1'b0;
      #1;
      checks++;
      if ({is_pulse, rightRot_pulse, leftRot_pulse, bwd_pulse, fwd_pulse, btn_level} !== 9'd0) begin
         errors++;
         $display("FAIL midhold_reset_outputs: got=%b want=0", {is_pulse, rightRot_pulse,
                  leftRot_pulse, bwd_pulse, fwd_pulse, btn_level});
      end
      tick(3);
      rst_n = 1'b1;
      tick(30);
      checks++;
      if (exp_q.size() != 0 || btn_level !== 4'b0000) begin
         errors++;
         $display("FAIL midhold_after: got queue=%0d level=%b want queue=0 level=0000",
                  exp_q.size(), btn_level);
         exp_q.delete();
      end
   endtask

`ifdef AUTO_REPEAT_EN
   task automatic test_auto_repeat;
      int unsigned c;
      c = cyc;
      btn_fwd = 1'b1;
      expect_pulse(c + 8, 4'b0001);
      for (int unsigned k = 20; k <= 70; k += 10) expect_pulse(c + 8 + k, 4'b0001);
      tick(78);
      btn_fwd = 1'b0;
      tick(40);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL repeat_missing: got=%0d pending expectations want=0", exp_q.size());
         exp_q.delete();
      end
   endtask
`endif

   initial begin
      test_reset;
      test_clean_press;
      test_bounce;
      test_simultaneous;
      test_reset_mid_hold;
`ifdef AUTO_REPEAT_EN
      test_auto_repeat;
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
